// File: rtl/pow2_approx_pipe.sv
// Three-stage 2^x approximator: split x into integer/fraction, build mantissa 1+f (+ optional
// quadratic correction), then shift by the integer part with saturation. Global-stall valid/ready.
module pow2_approx_pipe #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_x,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_y,
    output logic                out_sat
);

    localparam int IB  = W - FRAC;
    localparam int ONE = 1 << FRAC;
    localparam logic signed [IB-1:0] I_SAT = IB'(IB - 1);
    localparam logic signed [W-1:0]  Y_MAX = {1'b0, {(W-1){1'b1}}};

    // M(f) = 1 + f, plus c = ~0.344*f*(1-f) in corrected mode; every shift truncates.
    function automatic logic [W:0] mantissa(input logic [FRAC-1:0] f, input logic mode);
        logic [FRAC:0]     omf;
        logic [2*FRAC+1:0] prod;
        logic [2*FRAC+1:0] p;
        logic [W:0]        c;
        omf  = (FRAC+1)'(ONE) - {1'b0, f};
        prod = (2*FRAC+2)'(f) * (2*FRAC+2)'(omf);
        p    = prod >> FRAC;
        c    = (W+1)'(p >> 2) + (W+1)'(p >> 4) + (W+1)'(p >> 5);
        mantissa = (W+1)'(ONE) + (W+1)'(f) + (mode ? c : '0);
    endfunction

    // Scale the mantissa by 2^i; clamp to max positive once i reaches the top integer bit.
    function automatic logic signed [W-1:0] scale_sat(input logic [W:0] m,
                                                      input logic signed [IB-1:0] i);
        logic [IB-1:0] nsh;
        nsh = -i;
        if (i >= I_SAT) begin
            scale_sat = Y_MAX;
        end else if (!i[IB-1]) begin
            scale_sat = W'((2*W+1)'(m) << $unsigned(i));
        end else if (32'(nsh) >= W) begin
            scale_sat = '0;
        end else begin
            scale_sat = W'((2*W+1)'(m) >> nsh);
        end
    endfunction

    logic                 advance;
    logic                 vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q, vld_p3_d, vld_p3_q;
    logic signed [IB-1:0] i_p1_d, i_p1_q, i_p2_d, i_p2_q;
    logic [FRAC-1:0]      f_p1_d, f_p1_q;
    logic                 mode_p1_d, mode_p1_q;
    logic [W:0]           m_p2_d, m_p2_q;
    logic signed [W-1:0]  y_p3_d, y_p3_q;
    logic                 sat_p3_d, sat_p3_q;

    assign advance   = !vld_p3_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p3_q;
    assign out_y     = y_p3_q;
    assign out_sat   = sat_p3_q;

    always_comb begin
        vld_p1_d  = vld_p1_q;
        vld_p2_d  = vld_p2_q;
        vld_p3_d  = vld_p3_q;
        i_p1_d    = i_p1_q;
        f_p1_d    = f_p1_q;
        mode_p1_d = mode_p1_q;
        i_p2_d    = i_p2_q;
        m_p2_d    = m_p2_q;
        y_p3_d    = y_p3_q;
        sat_p3_d  = sat_p3_q;
        if (advance) begin
            vld_p1_d = in_valid;
            vld_p2_d = vld_p1_q;
            vld_p3_d = vld_p2_q;
            // Data registers only load behind a valid beat so idle inputs never reach state.
            if (in_valid) begin
                i_p1_d    = in_x[W-1:FRAC];
                f_p1_d    = in_x[FRAC-1:0];
                mode_p1_d = in_mode;
            end
            if (vld_p1_q) begin
                i_p2_d = i_p1_q;
                m_p2_d = mantissa(f_p1_q, mode_p1_q);
            end
            if (vld_p2_q) begin
                y_p3_d   = scale_sat(m_p2_q, i_p2_q);
                sat_p3_d = (i_p2_q >= I_SAT);
            end
        end
    end

    // Control and visible outputs: cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            y_p3_q   <= '0;
            sat_p3_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            y_p3_q   <= y_p3_d;
            sat_p3_q <= sat_p3_d;
        end
    end

    // Internal datapath registers carry no reset.
    always_ff @(posedge clk) begin
        i_p1_q    <= i_p1_d;
        f_p1_q    <= f_p1_d;
        mode_p1_q <= mode_p1_d;
        i_p2_q    <= i_p2_d;
        m_p2_q    <= m_p2_d;
    end

endmodule

// File: tb/tb_pow2_approx_pipe.sv
// Randomised bench for pow2_approx_pipe with an arithmetic reference model and a scoreboard.
module tb_pow2_approx_pipe;

    localparam int W    = 16;
    localparam int FRAC = 12;
    localparam int IB   = W - FRAC;
    localparam int ONE  = 1 << FRAC;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_sat;

    pow2_approx_pipe #(.W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic         sat;
        bit           hc;
        logic [W-1:0] cy;
        logic         csat;
        string        tag;
    } exp_t;

    exp_t         sbq[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           win      = 0;
    int           n_acc    = 0;
    int           first_acc, first_out, last_out, out_cnt;
    bit           prev_stall = 0;
    logic [W-1:0] prev_y;
    logic         prev_sat;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // 2^x = 2^i * M(f) with i = floor(x), f = x - i, computed with plain integer arithmetic.
    function automatic void model(input logic [W-1:0] x, input logic md,
                                  output logic [W-1:0] y, output logic sat);
        int xi, i, f, m, p, r;
        xi = int'($signed(x));
        i  = xi >>> FRAC;
        f  = xi - i * ONE;
        m  = ONE + f;
        if (md) begin
            p = (f * (ONE - f)) / ONE;
            m = m + p / 4 + p / 16 + p / 32;
        end
        sat = 1'b0;
        if (i >= IB - 1) begin
            r   = (1 << (W - 1)) - 1;
            sat = 1'b1;
        end else if (i >= 0) begin
            r = m * (1 << i);
        end else if (-i >= W) begin
            r = 0;
        end else begin
            r = m / (1 << (-i));
        end
        y = W'(r);
    endfunction

    task automatic cycle(input logic iv, input logic [W-1:0] x, input logic md, input logic ordy,
                         input bit hc = 0, input logic [W-1:0] cy = '0, input logic cs = 1'b0,
                         input string tag = "rnd");
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        in_x      = x;
        in_mode   = md;
        out_ready = ordy;
        #1;
        win++;
        check_eq("in_ready", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
        if (prev_stall) begin
            check_eq("stall_valid", {31'b0, out_valid}, 32'd1);
            check_eq("stall_y", {16'b0, out_y}, {16'b0, prev_y});
            check_eq("stall_sat", {31'b0, out_sat}, {31'b0, prev_sat});
        end
        if (out_valid) begin
            if (first_out < 0) first_out = win;
            last_out = win;
            out_cnt++;
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check_eq("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check_eq({e.tag, " y"}, {16'b0, out_y}, {16'b0, e.y});
                check_eq({e.tag, " sat"}, {31'b0, out_sat}, {31'b0, e.sat});
                if (e.hc) begin
                    check_eq({e.tag, " y_const"}, {16'b0, out_y}, {16'b0, e.cy});
                    check_eq({e.tag, " sat_const"}, {31'b0, out_sat}, {31'b0, e.csat});
                end
            end
        end
        if (in_valid && in_ready) begin
            model(in_x, in_mode, e.y, e.sat);
            e.hc = hc; e.cy = cy; e.csat = cs; e.tag = tag;
            sbq.push_back(e);
            n_acc++;
            if (first_acc < 0) first_acc = win;
        end
        prev_stall = out_valid && !out_ready;
        prev_y     = out_y;
        prev_sat   = out_sat;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 100 && sbq.size() > 0; k++) cycle(1'b0, W'($urandom), 1'b0, 1'b1);
        check_eq({tag, " drained"}, sbq.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        first_acc = -1; first_out = -1; last_out = -1; out_cnt = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("reset out_y", {16'b0, out_y}, 32'd0);
        check_eq("reset out_sat", {31'b0, out_sat}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("reset in_ready", {31'b0, in_ready}, 32'd1);

        // T1 / T2 / T3 directed beats
        cycle(1, 16'h0000, 0, 1, 1, 16'h1000, 0, "T1 x=0000");
        cycle(1, 16'h1800, 0, 1, 1, 16'h3000, 0, "T1 x=1800");
        cycle(1, 16'hF000, 0, 1, 1, 16'h0800, 0, "T1 x=F000");
        cycle(1, 16'h1800, 1, 1, 1, 16'h32C0, 0, "T2 x=1800 m1");
        cycle(1, 16'h0000, 1, 1, 1, 16'h1000, 0, "T2 x=0000 m1");
        cycle(1, 16'h1800, 0, 1, 1, 16'h3000, 0, "T2 x=1800 m0");
        cycle(1, 16'h1800, 1, 1, 1, 16'h32C0, 0, "T2 x=1800 m1b");
        cycle(1, 16'h3000, 0, 1, 1, 16'h7FFF, 1, "T3 x=3000");
        cycle(1, 16'h3000, 1, 1, 1, 16'h7FFF, 1, "T3 x=3000 m1");
        cycle(1, 16'h2FFF, 0, 1, 1, 16'h7FFC, 0, "T3 x=2FFF");
        cycle(1, 16'h8000, 0, 1, 1, 16'h0010, 0, "T3 x=8000");
        cycle(1, 16'h7FFF, 1, 1, 1, 16'h7FFF, 1, "T3 x=7FFF");
        drain("T1-T3");

        // T4 latency and throughput
        first_acc = -1; first_out = -1; last_out = -1; out_cnt = 0;
        for (int k = 0; k < 20; k++) cycle(1'b1, W'($urandom), 1'($urandom), 1'b1, 0, '0, 0, "T4");
        drain("T4");
        check_eq("T4 latency", first_out - first_acc, 32'd3);
        check_eq("T4 beat count", out_cnt, 32'd20);
        check_eq("T4 back-to-back", last_out - first_out, 32'd19);

        // T5 random backpressure and input gaps
        n_acc = 0;
        for (int k = 0; k < 6000 && n_acc < 1000; k++)
            cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom),
                  1'($urandom), 0, '0, 0, "T5");
        check_eq("T5 accepted", n_acc, 32'd1000);
        drain("T5");

        // T6 reset with beats in flight
        for (int k = 0; k < 3; k++) cycle(1'b1, W'($urandom), 1'($urandom), 1'b1, 0, '0, 0, "T6");
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("T6 in flight", {31'b0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("T6 async out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("T6 async out_y", {16'b0, out_y}, 32'd0);
        check_eq("T6 async out_sat", {31'b0, out_sat}, 32'd0);
        sbq.delete();
        prev_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_cnt = 0;
        for (int k = 0; k < 10; k++) cycle(1'b0, W'($urandom), 1'($urandom), 1'b1);
        check_eq("T6 no stale beat", out_cnt, 32'd0);
        cycle(1, 16'hF000, 0, 1, 1, 16'h0800, 0, "T6 post x=F000");
        drain("T6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
